// File: rtl/mtm_btn_debouncer_pkg.sv
// Shared types and defaults for the button debouncer.
package mtm_btn_pkg;

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_RISE = 2'd1,
        ST_HIGH = 2'd2,
        ST_FALL = 2'd3
    } btn_state_t;

    // 1 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/mtm_btn_debouncer_channel.sv
// One button channel: two-flop synchronizer, debounce FSM and stability counter.
module mtm_btn_debounce_channel
    import mtm_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_async,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    // The state-entry edge already consumed one stable sample, so the window
    // closes one count early to land the transition on edge 2+DEBOUNCE_CYCLES.
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 2);

    logic       r_sync_meta;
    logic       r_sync;
    btn_state_t r_state;
    btn_state_t w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic       r_press;
    logic       r_release;
    logic       w_press_nxt;
    logic       w_release_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync_meta <= i_btn_async;
            r_sync      <= r_sync_meta;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (r_sync) begin
                    w_state_nxt = ST_RISE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RISE: begin
                if (!r_sync) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TERM) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_HIGH: begin
                if (!r_sync) begin
                    w_state_nxt = ST_FALL;
                    w_cnt_nxt   = '0;
                end
            end
            ST_FALL: begin
                if (r_sync) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TERM) begin
                    w_state_nxt   = ST_LOW;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_LOW;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign o_level   = (r_state == ST_HIGH) || (r_state == ST_FALL);
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/mtm_btn_debouncer.sv
// Button input conditioner: per-channel debounce plus sticky pending flags and irq.
module mtm_btn_debouncer
    import mtm_btn_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_async,
    input  logic [NUM_BTN-1:0] pend_clr,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_pending,
    output logic               irq
);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_release;
    logic [NUM_BTN-1:0] r_pending;
    logic               r_irq;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        mtm_btn_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_btn_async(btn_async[g]),
            .o_level    (w_level[g]),
            .o_press    (w_press[g]),
            .o_release  (w_release[g])
        );
    end

    // A press landing in the same cycle as its clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~pend_clr) | w_press;
            r_irq     <= |r_pending;
        end
    end

    assign btn_level   = w_level;
    assign btn_press   = w_press;
    assign btn_release = w_release;
    assign btn_pending = r_pending;
    assign irq         = r_irq;

endmodule

// File: tb/tb_mtm_btn_debouncer.sv
// Scoreboard bench for mtm_btn_debouncer with DEBOUNCE_CYCLES=8.
module tb_mtm_btn_debouncer;

    localparam int S_LVL = 0;
    localparam int S_PRS = 1;
    localparam int S_REL = 2;
    localparam int S_PND = 3;
    localparam int S_IRQ = 4;

    typedef struct {
        int         when;
        string      tag;
        int         sel;
        logic [3:0] val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] btn_async;
    logic [3:0] pend_clr;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_pending;
    logic       irq;

    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t sbq[$];

    mtm_btn_debouncer #(
        .NUM_BTN        (4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_async  (btn_async),
        .pend_clr   (pend_clr),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_pending(btn_pending),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] observe(input int sel);
        case (sel)
            S_LVL:   return btn_level;
            S_PRS:   return btn_press;
            S_REL:   return btn_release;
            S_PND:   return btn_pending;
            default: return {3'b000, irq};
        endcase
    endfunction

    task automatic exp_at(input int when, input string tag, input int sel, input logic [3:0] val);
        exp_t e;
        int   idx;
        e.when = when;
        e.tag  = tag;
        e.sel  = sel;
        e.val  = val;
        idx = sbq.size();
        for (int i = 0; i < sbq.size(); i++) begin
            if (sbq[i].when > when) begin
                idx = i;
                break;
            end
        end
        sbq.insert(idx, e);
    endtask

    // Pop every expectation that has come due and compare against the DUT.
    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].when <= cyc) begin
            e = sbq.pop_front();
            chk(e.tag, {28'd0, observe(e.sel)}, {28'd0, e.val});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 200) begin
            step();
            n++;
        end
        if (sbq.size() > 0) begin
            chk("drain_timeout", sbq.size(), 0);
            sbq.delete();
        end
        step();
    endtask

    task automatic clear_pending(input logic [3:0] mask, input logic [3:0] remain, input logic irq_after);
        int c;
        c = cyc;
        pend_clr = mask;
        exp_at(c + 1, "clr_pnd", S_PND, remain);
        exp_at(c + 2, "clr_irq", S_IRQ, {3'b000, irq_after});
        step();
        pend_clr = 4'h0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int r;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        btn_async = 4'h0;
        pend_clr  = 4'h0;

        repeat (3) step();
        chk("rst_lvl", btn_level, 4'h0);
        chk("rst_prs", btn_press, 4'h0);
        chk("rst_rel", btn_release, 4'h0);
        chk("rst_pnd", btn_pending, 4'h0);
        chk("rst_irq", irq, 1'b0);
        rst = 1'b0;
        s = cyc;
        exp_at(s + 1,   "idle_lvl", S_LVL, 4'h0);
        exp_at(s + 50,  "idle_prs", S_PRS, 4'h0);
        exp_at(s + 100, "idle_lvl100", S_LVL, 4'h0);
        exp_at(s + 100, "idle_pnd100", S_PND, 4'h0);
        exp_at(s + 100, "idle_irq100", S_IRQ, 4'h0);
        drain();

        // Single press on channel 0
        s = cyc;
        btn_async = 4'h1;
        exp_at(s + 9,  "a_lvl9",  S_LVL, 4'h0);
        exp_at(s + 9,  "a_prs9",  S_PRS, 4'h0);
        exp_at(s + 10, "a_lvl10", S_LVL, 4'h1);
        exp_at(s + 10, "a_prs10", S_PRS, 4'h1);
        exp_at(s + 10, "a_pnd10", S_PND, 4'h0);
        exp_at(s + 11, "a_prs11", S_PRS, 4'h0);
        exp_at(s + 11, "a_pnd11", S_PND, 4'h1);
        exp_at(s + 11, "a_irq11", S_IRQ, 4'h0);
        exp_at(s + 12, "a_irq12", S_IRQ, 4'h1);
        drain();
        clear_pending(4'h1, 4'h0, 1'b0);
        s = cyc;
        btn_async = 4'h0;
        exp_at(s + 9,  "a_rlvl9",  S_LVL, 4'h1);
        exp_at(s + 10, "a_rlvl10", S_LVL, 4'h0);
        exp_at(s + 10, "a_rel10",  S_REL, 4'h1);
        exp_at(s + 11, "a_rel11",  S_REL, 4'h0);
        drain();

        // Seven-cycle glitch on channel 1 must be ignored
        s = cyc;
        btn_async = 4'h2;
        exp_at(s + 10, "b_glvl", S_LVL, 4'h0);
        exp_at(s + 10, "b_gprs", S_PRS, 4'h0);
        exp_at(s + 12, "b_gpnd", S_PND, 4'h0);
        exp_at(s + 14, "b_glvl14", S_LVL, 4'h0);
        repeat (7) step();
        btn_async = 4'h0;
        drain();
        s = cyc;
        btn_async = 4'h2;
        exp_at(s + 9,  "b_lvl9",   S_LVL, 4'h0);
        exp_at(s + 10, "b_lvl10",  S_LVL, 4'h2);
        exp_at(s + 10, "b_prs10",  S_PRS, 4'h2);
        exp_at(s + 11, "b_pnd11",  S_PND, 4'h2);
        exp_at(s + 17, "b_lvl17",  S_LVL, 4'h2);
        exp_at(s + 18, "b_rel18",  S_REL, 4'h2);
        exp_at(s + 18, "b_lvl18",  S_LVL, 4'h0);
        repeat (8) step();
        btn_async = 4'h0;
        drain();
        clear_pending(4'h2, 4'h0, 1'b0);

        // All channels at once, then partial clear
        s = cyc;
        btn_async = 4'hF;
        exp_at(s + 10, "c_prs10", S_PRS, 4'hF);
        exp_at(s + 10, "c_lvl10", S_LVL, 4'hF);
        exp_at(s + 11, "c_prs11", S_PRS, 4'h0);
        exp_at(s + 11, "c_pnd11", S_PND, 4'hF);
        exp_at(s + 12, "c_irq12", S_IRQ, 4'h1);
        repeat (12) step();
        pend_clr = 4'h5;
        exp_at(s + 13, "c_pnd13", S_PND, 4'hA);
        exp_at(s + 13, "c_irq13", S_IRQ, 4'h1);
        exp_at(s + 14, "c_irq14", S_IRQ, 4'h1);
        step();
        pend_clr = 4'h0;
        drain();
        s = cyc;
        btn_async = 4'h0;
        exp_at(s + 10, "c_rel10", S_REL, 4'hF);
        exp_at(s + 10, "c_rlvl10", S_LVL, 4'h0);
        drain();
        clear_pending(4'hF, 4'h0, 1'b0);

        // Clear coinciding with press: set wins
        s = cyc;
        btn_async = 4'h4;
        exp_at(s + 10, "d_prs10", S_PRS, 4'h4);
        exp_at(s + 11, "d_pnd11", S_PND, 4'h4);
        exp_at(s + 12, "d_irq12", S_IRQ, 4'h1);
        repeat (10) step();
        pend_clr = 4'h4;
        step();
        pend_clr = 4'h0;
        drain();
        repeat (5) step();
        r = cyc;
        btn_async = 4'h0;
        exp_at(r + 9,  "d_lvl9",  S_LVL, 4'h4);
        exp_at(r + 9,  "d_rel9",  S_REL, 4'h0);
        exp_at(r + 10, "d_rel10", S_REL, 4'h4);
        exp_at(r + 10, "d_lvl10", S_LVL, 4'h0);
        exp_at(r + 11, "d_rel11", S_REL, 4'h0);
        drain();

        // Reset four cycles into the rise window with the button held
        btn_async = 4'h8;
        repeat (7) step();
        rst = 1'b1;
        #1;
        chk("e_rst_lvl", btn_level, 4'h0);
        chk("e_rst_pnd", btn_pending, 4'h0);
        chk("e_rst_irq", irq, 1'b0);
        repeat (3) begin
            step();
            chk("e_hold_prs", btn_press, 4'h0);
            chk("e_hold_lvl", btn_level, 4'h0);
        end
        rst = 1'b0;
        r = cyc;
        exp_at(r + 9,  "e_prs9",  S_PRS, 4'h0);
        exp_at(r + 9,  "e_lvl9",  S_LVL, 4'h0);
        exp_at(r + 10, "e_prs10", S_PRS, 4'h8);
        exp_at(r + 10, "e_lvl10", S_LVL, 4'h8);
        exp_at(r + 11, "e_pnd11", S_PND, 4'h8);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
